// File: rtl/sva_slot_scheduler.sv
// rtl/sva_slot_scheduler.sv - thread-slot pool that allocates attempts and issues them to a shared evaluator
// Optional statistics (drop_count, max_active) built only when SVA_SCHED_STATS_EN is defined.
module sva_slot_scheduler #(
    parameter int SLOTS       = 8,
    parameter int STATE_WIDTH = 8,
    parameter int TIMER_WIDTH = 16,
    localparam int SW = $clog2(SLOTS),
    localparam int CW = $clog2(SLOTS + 1)
) (
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   step,
    input  logic                   start_req,
    input  logic [STATE_WIDTH-1:0] start_state,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [SW-1:0]          issue_slot,
    output logic [STATE_WIDTH-1:0] issue_state,
    output logic [TIMER_WIDTH-1:0] issue_period,
    input  logic                   res_valid,
    input  logic [SW-1:0]          res_slot,
    input  logic [STATE_WIDTH-1:0] res_state,
    input  logic                   res_active,
    output logic                   busy,
    output logic                   round_done,
    output logic [CW-1:0]          active_count,
    output logic [TIMER_WIDTH-1:0] period,
    output logic                   overflow,
    output logic                   step_overrun,
    output logic                   protocol_err,
    output logic [TIMER_WIDTH-1:0] drop_count,
    output logic [CW-1:0]          max_active
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]             fsm, fsm_n;
    logic [SLOTS-1:0]       valid, valid_n, outst, outst_n, pend, pend_n;
    logic [STATE_WIDTH-1:0] state_q [SLOTS];
    logic [TIMER_WIDTH-1:0] start_per [SLOTS];
    logic                   alloc, free_found, res_hit, done_n, drop;
    logic [SW-1:0]          free_slot, sel;
    logic [CW-1:0]          count_n;
    logic [STATE_WIDTH-1:0] sel_state;
    logic [TIMER_WIDTH-1:0] sel_per;

    always_comb begin
        valid_n    = valid;
        outst_n    = outst;
        pend_n     = pend;
        fsm_n      = fsm;
        alloc      = 1'b0;
        done_n     = 1'b0;
        free_found = 1'b0;
        free_slot  = '0;
        res_hit    = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_slot  = SW'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (res_valid && res_slot == SW'(i) && outst[i]) res_hit = 1'b1;
        end
        // An issue and a result never target the same slot, so both updates can apply together.
        if (issue_valid && issue_ready) begin
            pend_n[issue_slot]  = 1'b0;
            outst_n[issue_slot] = 1'b1;
        end
        if (res_hit) begin
            outst_n[res_slot] = 1'b0;
            if (!res_active) valid_n[res_slot] = 1'b0;
        end
        case (fsm)
            IDLE: begin
                if (step) begin
                    pend_n = valid;
                    if (start_req && free_found) begin
                        alloc              = 1'b1;
                        valid_n[free_slot] = 1'b1;
                        pend_n[free_slot]  = 1'b1;
                    end
                    fsm_n = (pend_n != '0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                if (pend_n == '0) fsm_n = DRAIN;
            end
            DRAIN: begin
                if (outst_n == '0) begin
                    fsm_n  = IDLE;
                    done_n = 1'b1;
                end
            end
            default: fsm_n = IDLE;
        endcase
        sel = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pend_n[i]) sel = SW'(i);
        end
        // A slot allocated this cycle is not yet in the pool arrays; forward its fields.
        sel_state = (alloc && free_slot == sel) ? start_state : state_q[sel];
        sel_per   = (alloc && free_slot == sel) ? period : start_per[sel];
        count_n   = '0;
        for (int i = 0; i < SLOTS; i++) count_n = count_n + CW'(valid_n[i]);
    end

    assign drop = (fsm == IDLE) && step && start_req && !free_found;

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            fsm          <= IDLE;
            valid        <= '0;
            outst        <= '0;
            pend         <= '0;
            busy         <= 1'b0;
            round_done   <= 1'b0;
            active_count <= '0;
            issue_valid  <= 1'b0;
            issue_slot   <= '0;
            issue_state  <= '0;
            issue_period <= '0;
            period       <= '0;
            overflow     <= 1'b0;
            step_overrun <= 1'b0;
            protocol_err <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i]   <= '0;
                start_per[i] <= '0;
            end
        end else begin
            fsm          <= fsm_n;
            valid        <= valid_n;
            outst        <= outst_n;
            pend         <= pend_n;
            busy         <= (fsm_n != IDLE);
            round_done   <= done_n;
            active_count <= count_n;
            issue_valid  <= (fsm_n == ISSUE);
            issue_slot   <= sel;
            issue_state  <= sel_state;
            issue_period <= sel_per;
            if (fsm == IDLE && step) period <= period + TIMER_WIDTH'(1);
            if (fsm != IDLE && step) step_overrun <= 1'b1;
            if (drop) overflow <= 1'b1;
            if (res_valid && !res_hit) protocol_err <= 1'b1;
            if (alloc) begin
                state_q[free_slot]   <= start_state;
                start_per[free_slot] <= period;
            end
            if (res_hit) state_q[res_slot] <= res_state;
        end
    end

`ifdef SVA_SCHED_STATS_EN
    logic [TIMER_WIDTH-1:0] drop_q;
    logic [CW-1:0]          max_q;

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            drop_q <= '0;
            max_q  <= '0;
        end else begin
            if (drop && drop_q != '1) drop_q <= drop_q + TIMER_WIDTH'(1);
            if (count_n > max_q) max_q <= count_n;
        end
    end

    assign drop_count = drop_q;
    assign max_active = max_q;
`else
    assign drop_count = '0;
    assign max_active = '0;
`endif

endmodule

// File: tb/tb_sva_slot_scheduler.sv
// tb/tb_sva_slot_scheduler.sv - directed self-checking bench for sva_slot_scheduler
module tb_sva_slot_scheduler;
    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        step = 1'b0;
    logic        start_req = 1'b0;
    logic [7:0]  start_state = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [2:0]  issue_slot;
    logic [7:0]  issue_state;
    logic [15:0] issue_period;
    logic        res_valid = 1'b0;
    logic [2:0]  res_slot = '0;
    logic [7:0]  res_state = '0;
    logic        res_active = 1'b1;
    logic        busy, round_done, overflow, step_overrun, protocol_err;
    logic [3:0]  active_count, max_active;
    logic [15:0] period, drop_count;

    int vectors = 0;
    int miscompares = 0;

    bit          exp_valid [8];
    logic [7:0]  exp_state [8];
    logic [15:0] exp_per [8];
    int          model_period;

    sva_slot_scheduler dut (
        .gclk(gclk), .grst(grst), .step(step), .start_req(start_req), .start_state(start_state),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_slot(issue_slot),
        .issue_state(issue_state), .issue_period(issue_period), .res_valid(res_valid),
        .res_slot(res_slot), .res_state(res_state), .res_active(res_active), .busy(busy),
        .round_done(round_done), .active_count(active_count), .period(period),
        .overflow(overflow), .step_overrun(step_overrun), .protocol_err(protocol_err),
        .drop_count(drop_count), .max_active(max_active)
    );

    always #5 gclk = ~gclk;

    task automatic tick;
        @(posedge gclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one round with an echo evaluator: each accepted slot returns state+1 one cycle later.
    task automatic run_round(input bit st, input logic [7:0] ss, input int kill, input bit poke);
        bit pend [8];
        bit acc, done;
        int k, f, left;
        for (int i = 0; i < 8; i++) pend[i] = exp_valid[i];
        f = -1;
        if (st) begin
            for (int i = 7; i >= 0; i--) if (!exp_valid[i]) f = i;
            if (f >= 0) begin
                exp_valid[f] = 1'b1;
                exp_state[f] = ss;
                exp_per[f]   = model_period[15:0];
                pend[f]      = 1'b1;
            end
        end
        model_period++;
        step = 1'b1; start_req = st; start_state = ss;
        tick;
        step = 1'b0; start_req = 1'b0;
        done = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (round_done) begin
                done = 1'b1;
            end else begin
                acc = 1'b0;
                if (issue_valid) begin
                    k = -1;
                    for (int i = 7; i >= 0; i--) if (pend[i]) k = i;
                    chk("rr_issue_slot", 32'(issue_slot), k);
                    if (k >= 0) begin
                        chk("rr_issue_state", 32'(issue_state), 32'(exp_state[k]));
                        chk("rr_issue_period", 32'(issue_period), 32'(exp_per[k]));
                        pend[k] = 1'b0;
                        acc = 1'b1;
                    end
                end
                if (poke && c == 0) begin
                    step = 1'b1; res_valid = 1'b1; res_slot = 3'd7; res_state = 8'hee; res_active = 1'b0;
                end
                tick;
                step = 1'b0;
                res_valid = acc;
                res_active = 1'b1;
                if (acc) begin
                    res_slot     = 3'(k);
                    res_state    = exp_state[k] + 8'd1;
                    res_active   = (k != kill);
                    exp_state[k] = exp_state[k] + 8'd1;
                    if (k == kill) exp_valid[k] = 1'b0;
                end
            end
        end
        res_valid = 1'b0;
        res_active = 1'b1;
        chk("rr_round_done", 32'(done), 1);
        left = 0;
        for (int i = 0; i < 8; i++) left += int'(pend[i]);
        chk("rr_all_issued", left, 0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_active", 32'(active_count), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_flags", {29'd0, overflow, step_overrun, protocol_err}, 0);
        chk("rst_round_done", 32'(round_done), 0);
        #2 grst = 1'b0;

        // Single attempt, one-cycle result latency
        step = 1'b1; start_req = 1'b1; start_state = 8'h01;
        tick;
        step = 1'b0; start_req = 1'b0;
        chk("t1_issue_valid", 32'(issue_valid), 1);
        chk("t1_issue_slot", 32'(issue_slot), 0);
        chk("t1_issue_state", 32'(issue_state), 8'h01);
        chk("t1_issue_period", 32'(issue_period), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_period", 32'(period), 1);
        chk("t1_active", 32'(active_count), 1);
        tick;
        chk("t1_issue_drop", 32'(issue_valid), 0);
        chk("t1_not_done", 32'(round_done), 0);
        res_valid = 1'b1; res_slot = 3'd0; res_state = 8'h05; res_active = 1'b1;
        tick;
        res_valid = 1'b0;
        chk("t1_round_done", 32'(round_done), 1);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_active_after", 32'(active_count), 1);
        tick;
        chk("t1_done_pulse", 32'(round_done), 0);

        // Second attempt joins slot 1
        step = 1'b1; start_req = 1'b1; start_state = 8'h10;
        tick;
        step = 1'b0; start_req = 1'b0;
        chk("t2a_slot0", 32'(issue_slot), 0);
        chk("t2a_state0", 32'(issue_state), 8'h05);
        chk("t2a_period", 32'(period), 2);
        chk("t2a_active", 32'(active_count), 2);
        tick;
        chk("t2a_slot1", 32'(issue_slot), 1);
        chk("t2a_state1", 32'(issue_state), 8'h10);
        chk("t2a_per1", 32'(issue_period), 1);
        res_valid = 1'b1; res_slot = 3'd0; res_state = 8'h06;
        tick;
        chk("t2a_drain", 32'(issue_valid), 0);
        chk("t2a_not_done", 32'(round_done), 0);
        res_slot = 3'd1; res_state = 8'h11;
        tick;
        res_valid = 1'b0;
        chk("t2a_done", 32'(round_done), 1);
        tick;

        // Three slots, results returned out of order 2, 0, 1
        step = 1'b1; start_req = 1'b1; start_state = 8'h20;
        tick;
        step = 1'b0; start_req = 1'b0;
        chk("t2b_slot0", 32'(issue_slot), 0);
        chk("t2b_state0", 32'(issue_state), 8'h06);
        chk("t2b_active", 32'(active_count), 3);
        tick;
        chk("t2b_slot1", 32'(issue_slot), 1);
        chk("t2b_state1", 32'(issue_state), 8'h11);
        tick;
        chk("t2b_slot2", 32'(issue_slot), 2);
        chk("t2b_state2", 32'(issue_state), 8'h20);
        chk("t2b_per2", 32'(issue_period), 2);
        tick;
        chk("t2b_drain", 32'(issue_valid), 0);
        chk("t2b_busy", 32'(busy), 1);
        res_valid = 1'b1; res_slot = 3'd2; res_state = 8'h21;
        tick;
        chk("t2b_wait1", 32'(round_done), 0);
        res_slot = 3'd0; res_state = 8'h07;
        tick;
        chk("t2b_wait2", 32'(round_done), 0);
        res_slot = 3'd1; res_state = 8'h12;
        tick;
        res_valid = 1'b0;
        chk("t2b_done", 32'(round_done), 1);
        tick;

        for (int i = 0; i < 8; i++) begin
            exp_valid[i] = 1'b0; exp_state[i] = '0; exp_per[i] = '0;
        end
        exp_valid[0] = 1'b1; exp_state[0] = 8'h07; exp_per[0] = 16'd0;
        exp_valid[1] = 1'b1; exp_state[1] = 8'h12; exp_per[1] = 16'd1;
        exp_valid[2] = 1'b1; exp_state[2] = 8'h21; exp_per[2] = 16'd2;
        model_period = 3;

        // Fill the pool, then overflow it
        for (int i = 0; i < 5; i++) run_round(1'b1, 8'h30 + 8'(16 * i), -1, 1'b0);
        chk("full_active", 32'(active_count), 8);
        chk("full_period", 32'(period), 8);
        chk("full_no_ovf", 32'(overflow), 0);
        run_round(1'b1, 8'h99, -1, 1'b0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_active", 32'(active_count), 8);
`ifdef SVA_SCHED_STATS_EN
        chk("ovf_drop_count", 32'(drop_count), 1);
        chk("ovf_max_active", 32'(max_active), 8);
`else
        chk("ovf_drop_count", 32'(drop_count), 0);
        chk("ovf_max_active", 32'(max_active), 0);
`endif

        // Terminate slot 3, then reuse it
        run_round(1'b0, 8'h00, 3, 1'b0);
        chk("kill_active", 32'(active_count), 7);
        run_round(1'b1, 8'h55, -1, 1'b0);
        chk("reuse_active", 32'(active_count), 8);

        // Step during ISSUE plus a stray result
        chk("pre_overrun", 32'(step_overrun), 0);
        chk("pre_proto", 32'(protocol_err), 0);
        run_round(1'b0, 8'h00, -1, 1'b1);
        chk("overrun_flag", 32'(step_overrun), 1);
        chk("proto_flag", 32'(protocol_err), 1);
        chk("overrun_period", 32'(period), 32'(model_period[15:0]));
        chk("overrun_active", 32'(active_count), 8);

        // Reset with two results outstanding
        step = 1'b1; start_req = 1'b0;
        tick;
        step = 1'b0;
        tick;
        tick;
        chk("pre_rst_busy", 32'(busy), 1);
        grst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_issue_valid", 32'(issue_valid), 0);
        chk("arst_active", 32'(active_count), 0);
        chk("arst_period", 32'(period), 0);
        chk("arst_flags", {29'd0, overflow, step_overrun, protocol_err}, 0);
        chk("arst_stats", {12'd0, drop_count, max_active}, 0);
        #2 grst = 1'b0;
        res_valid = 1'b1; res_slot = 3'd1; res_state = 8'h01;
        tick;
        res_valid = 1'b0;
        chk("post_rst_proto", 32'(protocol_err), 1);
        for (int i = 0; i < 8; i++) exp_valid[i] = 1'b0;
        model_period = 0;
        run_round(1'b1, 8'h77, -1, 1'b0);
        chk("post_rst_active", 32'(active_count), 1);
        chk("post_rst_period", 32'(period), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sva_slot_scheduler.md
# sva_slot_scheduler

Thread-slot scheduler for the assertion-evaluation datapath. It owns a pool of SLOTS attempt threads. Each thread is an active flag, a start period and an FSM state. On every sampling step it allocates a slot for a new attempt, then issues every active slot, one per cycle, to a shared next-state evaluator over a valid/ready handshake. It writes the evaluator's results back into the pool. It sits between the gclk edge/step generator and the generated per-property next-state function.

## Interface
- SLOTS, 8: number of thread slots (2..32)
- STATE_WIDTH, 8: width of FSM state code
- TIMER_WIDTH, 16: width of step period counter
- gclk  in  1  clock
- grst  in  1  reset, asynchronous, active-high
- step  in  1  one-cycle pulse, start of a sampling round
- start_req  in  1  open a new attempt this round (sampled with step)
- start_state  in  STATE_WIDTH  initial FSM state of new attempt
- issue_valid  out  1  evaluation request valid
- issue_ready  in  1  evaluator accepts request
- issue_slot  out  $clog2(SLOTS)  slot being issued
- issue_state  out  STATE_WIDTH  current state of issued slot
- issue_period  out  TIMER_WIDTH  start period of issued slot
- res_valid  in  1  evaluator result valid (always accepted)
- res_slot  in  $clog2(SLOTS)  slot of result
- res_state  in  STATE_WIDTH  next state
- res_active  in  1  0 = attempt terminated (succ/fail/lazy), free slot
- busy  out  1  round in progress
- round_done  out  1  one-cycle pulse, round complete
- active_count  out  $clog2(SLOTS+1)  occupied slots
- period  out  TIMER_WIDTH  accepted step count
- overflow  out  1  sticky: start_req dropped, no free slot
- step_overrun  out  1  sticky: step received while busy
- protocol_err  out  1  sticky: result for a non-outstanding slot
- drop_count, max_active  out  TIMER_WIDTH, $clog2(SLOTS+1)  statistics (see Configuration)

## Operation
- Pool per slot: valid, outstanding, state, start_period. Reset clears all of them.
- FSM states: IDLE, ISSUE, DRAIN. Reset state is IDLE.
- IDLE, step=1:
  - period increments and wraps modulo 2^TIMER_WIDTH.
  - pending mask is loaded with the valid mask.
  - If start_req=1, the lowest-index free slot gets valid=1, state=start_state, start_period=period (pre-increment value). That slot also sets its pending bit.
  - If start_req=1 and no slot is free, the attempt is dropped and overflow is set.
  - Next state is ISSUE if pending is nonzero, otherwise DRAIN.
- ISSUE:
  - issue_* present the lowest-index pending slot.
  - On issue_valid&&issue_ready, that slot's pending bit clears and its outstanding bit sets.
  - When the last pending bit clears, the FSM moves to DRAIN.
- Results, in any state:
  - If res_valid and res_slot is outstanding, outstanding clears and state=res_state.
  - If res_active=0, the slot's valid also clears.
  - If res_valid arrives and res_slot is not outstanding, protocol_err is set and the pool is unchanged.
- DRAIN: when no outstanding bits remain, round_done=1 for one cycle and the FSM returns to IDLE.
- step while busy: ignored, step_overrun set. Pool, period and pending are unchanged.
- active_count is the popcount of valid after update, registered.
- busy = (FSM != IDLE).
- Results may return out of order and in the same cycle as an issue. An issue and a result for the same slot cannot coincide.

## Timing
- All outputs are registered. Reset values: all 0; issue_valid=0, busy=0, sticky flags=0.
- The first issue_valid appears in the cycle after the step.
- Throughput: one issue per cycle while issue_ready=1. issue_valid must not drop, and issue_* must hold, until accepted.
- Minimum round with N active slots and zero-latency results is N+2 cycles from step to round_done.
- A result is visible in active_count and in the pool one cycle after res_valid.
- grst asserted mid-round aborts the round immediately: pool, counters and flags clear. Results arriving after grst deasserts with no outstanding slot set protocol_err.

## Configuration
- SVA_SCHED_STATS_EN defined:
  - drop_count counts dropped start_req, saturating at all-ones.
  - max_active tracks the high-water mark of active_count.
  - Both clear on grst.
- SVA_SCHED_STATS_EN undefined: drop_count and max_active are tied to 0 and their counters are not built. All other behaviour is identical.

## Test plan
- Reset, then step+start_req, start_state=1, ready=1, one-cycle result res_active=1 -> slot 0 issued the cycle after the step with issue_period=0; round_done at cycle 3; active_count=1; period=1.
- 3 active slots, ready=1, results returned in order slot 2, 0, 1 -> all three issued on consecutive cycles; round_done only after the third result; states updated per slot.
- SLOTS=8 all valid, step+start_req -> overflow=1; with the macro, drop_count=1; no slot overwritten.
- Result res_active=0 on slot 3 -> active_count drops by 1; next start_req allocates slot 3 if it is the lowest free slot.
- step pulsed during ISSUE, then res_valid for an idle slot -> step_overrun=1, protocol_err=1; the round still completes normally.
- grst asserted while 2 results are outstanding -> next cycle all outputs are 0 and the FSM is IDLE; a following step with start_req allocates slot 0.
